// File: rtl/exec_sequencer_pkg.sv
// Shared opcodes, instruction field positions, FSM states and flag indices.
package exec_sequencer_pkg;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_NOT = 5'h01;
  localparam logic [4:0] OP_AND = 5'h02;
  localparam logic [4:0] OP_OR  = 5'h03;
  localparam logic [4:0] OP_NEG = 5'h04;
  localparam logic [4:0] OP_ADD = 5'h05;
  localparam logic [4:0] OP_SUB = 5'h06;
  localparam logic [4:0] OP_MUL = 5'h07;
  localparam logic [4:0] OP_LD  = 5'h08;
  localparam logic [4:0] OP_STR = 5'h09;
  localparam logic [4:0] OP_JMP = 5'h0A;
  localparam logic [4:0] OP_JC  = 5'h0B;
  localparam logic [4:0] OP_JS  = 5'h0C;
  localparam logic [4:0] OP_JO  = 5'h0D;
  localparam logic [4:0] OP_JZ  = 5'h0E;
  localparam logic [4:0] OP_HLT = 5'h0F;

  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 27;
  localparam int unsigned RD_MSB   = 26;
  localparam int unsigned RD_LSB   = 24;
  localparam int unsigned RA_MSB   = 23;
  localparam int unsigned RA_LSB   = 21;
  localparam int unsigned RB_MSB   = 20;
  localparam int unsigned RB_LSB   = 18;
  localparam int unsigned ADDR_MSB = 15;
  localparam int unsigned ADDR_LSB = 0;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_O = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

endpackage

// File: rtl/exec_sequencer_reg_file.sv
// Register file: two combinational read ports, one synchronous write port.
module exec_sequencer_reg_file #(
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_a_idx_i,
  input  logic [IDX_W-1:0]     rd_b_idx_i,
  output logic [BITS_DATA-1:0] rd_a_o,
  output logic [BITS_DATA-1:0] rd_b_o,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [BITS_DATA-1:0] wr_data_i
);

  logic [BITS_DATA-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_a_o = regs_q[rd_a_idx_i];
  assign rd_b_o = regs_q[rd_b_idx_i];

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute controller driving the ALU and memory.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16,
  parameter int unsigned NUM_REGS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [BITS_DATA-1:0] mem_rdata,
  output logic [BITS_DATA-1:0] alu_a,
  output logic [BITS_DATA-1:0] alu_b,
  output logic [4:0]           alu_opcode,
  input  logic [BITS_DATA-1:0] alu_result,
  input  logic                 alu_c,
  input  logic                 alu_s,
  input  logic                 alu_o,
  input  logic                 alu_z,
  output logic [3:0]           flags,
  output logic [BITS_ADDR-1:0] pc,
  output logic                 halted,
  output logic                 illegal
);

  state_e               state_q, state_d;
  logic [BITS_ADDR-1:0] pc_q, pc_d;
  logic [BITS_DATA-1:0] instr_q, instr_d;
  logic [BITS_DATA-1:0] res_q, res_d;
  logic [BITS_DATA-1:0] alu_a_q, alu_a_d;
  logic [BITS_DATA-1:0] alu_b_q, alu_b_d;
  logic [4:0]           alu_op_q, alu_op_d;
  logic [3:0]           flags_q, flags_d;
  logic                 mem_we_q, mem_we_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
  logic                 rf_we;

  logic [4:0]           op;
  logic [2:0]           rd, ra, rb;
  logic [BITS_ADDR-1:0] addr;
  logic [BITS_DATA-1:0] rf_a, rf_b;
  logic                 unused_reserved;

  assign op   = instr_q[OP_MSB:OP_LSB];
  assign rd   = instr_q[RD_MSB:RD_LSB];
  assign ra   = instr_q[RA_MSB:RA_LSB];
  assign rb   = instr_q[RB_MSB:RB_LSB];
  assign addr = instr_q[ADDR_MSB:ADDR_LSB];
  assign unused_reserved = ^instr_q[17:16];

  exec_sequencer_reg_file #(
    .NUM_REGS  (NUM_REGS),
    .BITS_DATA (BITS_DATA)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .rd_a_idx_i (ra),
    .rd_b_idx_i (rb),
    .rd_a_o     (rf_a),
    .rd_b_o     (rf_b),
    .we_i       (rf_we),
    .wr_idx_i   (rd),
    .wr_data_i  (res_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      res_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_NOP;
      flags_q   <= '0;
      mem_we_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      res_q     <= res_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      flags_q   <= flags_d;
      mem_we_q  <= mem_we_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // mem_we is registered, so it is raised on the DECODE->MEM edge for STR
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    res_d     = res_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    flags_d   = flags_q;
    mem_we_d  = 1'b0;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        instr_d = mem_rdata;
        pc_d    = pc_q + BITS_ADDR'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        alu_a_d  = rf_a;
        alu_b_d  = rf_b;
        alu_op_d = op;
        state_d  = ST_FETCH;
        case (op)
          OP_NOT, OP_AND, OP_OR, OP_NEG,
          OP_ADD, OP_SUB, OP_MUL: state_d = ST_EXEC;
          OP_LD:  state_d = ST_MEM;
          OP_STR: begin
            state_d  = ST_MEM;
            mem_we_d = 1'b1;
          end
          OP_NOP: ;
          OP_HLT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          OP_JMP: pc_d = addr;
          OP_JC:  if (flags_q[FLAG_C]) pc_d = addr;
          OP_JS:  if (flags_q[FLAG_S]) pc_d = addr;
          OP_JO:  if (flags_q[FLAG_O]) pc_d = addr;
          OP_JZ:  if (flags_q[FLAG_Z]) pc_d = addr;
          default: illegal_d = 1'b1;
        endcase
      end
      ST_EXEC: begin
        res_d           = alu_result;
        flags_d[FLAG_S] = alu_s;
        flags_d[FLAG_Z] = alu_z;
        if (op != OP_MUL) begin
          flags_d[FLAG_C] = alu_c;
          flags_d[FLAG_O] = alu_o;
        end
        state_d = ST_WB;
      end
      ST_MEM: begin
        if (op == OP_LD) begin
          res_d   = mem_rdata;
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_addr  = pc_q;
    mem_wdata = '0;
    if (state_q == ST_MEM) begin
      mem_addr = addr;
      if (op == OP_STR) mem_wdata = rf_a;
    end
  end

  assign mem_we     = mem_we_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign flags      = flags_q;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer with behavioural ALU and 64K-word memory.
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_opcode;
  logic        alu_c, alu_s, alu_o, alu_z;
  logic [3:0]  flags;
  logic [15:0] pc;
  logic        halted, illegal;

  logic [31:0] mem [0:65535];
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [31:0] ld_data;

  int total = 0;
  int bad   = 0;

  exec_sequencer #(
    .BITS_DATA (32),
    .BITS_ADDR (16),
    .NUM_REGS  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_c      (alu_c),
    .alu_s      (alu_s),
    .alu_o      (alu_o),
    .alu_z      (alu_z),
    .flags      (flags),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // MUL drives C and O high so that the sequencer's hold of those flags is visible
  always_comb begin
    alu_result = '0;
    alu_c      = 1'b0;
    alu_o      = 1'b0;
    case (alu_opcode)
      OP_NOT: alu_result = ~alu_a;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_NEG: begin
        alu_result = -alu_a;
        alu_o      = (alu_a == 32'h8000_0000);
      end
      OP_ADD: begin
        {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_o = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_result = alu_a - alu_b;
        alu_c      = (alu_a < alu_b);
        alu_o      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_MUL: begin
        alu_result = alu_a * alu_b;
        alu_c      = 1'b1;
        alu_o      = 1'b1;
      end
      default: ;
    endcase
    alu_s = alu_result[31];
    alu_z = (alu_result == 32'h0);
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;   // {C,S,O,Z}
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [15:0] addr);
    return {op, rd, ra, rb, 2'b00, addr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1;
    ld_we = 1'b0;
  endtask

  // Leaves rst asserted; programs are loaded while the DUT is held in reset.
  task automatic clear_mem();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) load(16'(i), 32'h0);
    load(16'hFFFF, 32'h0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc"},     32'(pc), 32'h0);
    chk({tag, "_flags"},  32'(flags), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_illegal"},32'(illegal), 32'h0);
    chk({tag, "_we"},     32'(mem_we), 32'h0);
    chk({tag, "_alu_a"},  alu_a, 32'h0);
    chk({tag, "_alu_b"},  alu_b, 32'h0);
    chk({tag, "_aluop"},  32'(alu_opcode), 32'(OP_NOP));
  endtask

  int          we_cnt;
  int          we_cyc;
  logic [15:0] we_addr;
  logic [31:0] we_data;

  initial begin
    rst   = 1'b1;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    vecs[0] = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110};
    vecs[1] = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001};
    vecs[2] = '{OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0001};
    vecs[3] = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1100};
    vecs[4] = '{OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000};
    vecs[5] = '{OP_OR,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001};
    vecs[6] = '{OP_NOT, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0100};
    vecs[7] = '{OP_NEG, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0100};
    vecs[8] = '{OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 4'b0000};
    vecs[9] = '{OP_MUL, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 4'b0100};

    #2;
    check_reset("rst0");

    // LD r1; LD r2; OP r3,r1,r2; HLT -> 14 cycles
    for (int i = 0; i < 10; i++) begin
      clear_mem();
      load(16'h0000, enc(OP_LD, 3'd1, 3'd0, 3'd0, 16'h0010));
      load(16'h0001, enc(OP_LD, 3'd2, 3'd0, 3'd0, 16'h0011));
      load(16'h0002, enc(vecs[i].op, 3'd3, 3'd1, 3'd2, 16'h0000));
      load(16'h0003, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
      load(16'h0010, vecs[i].a);
      load(16'h0011, vecs[i].b);
      rst = 1'b0;
      run(13);
      chk($sformatf("v%0d_halt13", i), 32'(halted), 32'h0);
      run(1);
      chk($sformatf("v%0d_halt14", i), 32'(halted), 32'h1);
      chk($sformatf("v%0d_r3", i), dut.u_rf.regs_q[3], vecs[i].res);
      chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flg));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'h4);
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'h0);
    end

    // async reset from a halted, non-zero state
    rst = 1'b1;
    #1;
    check_reset("rst1");

    // SUB to zero then JZ taken
    clear_mem();
    load(16'h0000, enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'h0010));
    load(16'h0001, enc(OP_SUB, 3'd3, 3'd1, 3'd1, 16'h0000));
    load(16'h0002, enc(OP_JZ,  3'd0, 3'd0, 3'd0, 16'h0020));
    load(16'h0020, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
    load(16'h0010, 32'h0000_0007);
    rst = 1'b0;
    run(9);
    chk("jz_t_fetch_pc", 32'(pc), 32'h3);
    chk("jz_t_flags", 32'(flags), 32'h1);
    run(1);
    chk("jz_t_pc", 32'(pc), 32'h20);
    run(2);
    chk("jz_t_halt", 32'(halted), 32'h1);
    chk("jz_t_halt_pc", 32'(pc), 32'h21);

    // SUB non-zero then JZ not taken
    clear_mem();
    load(16'h0000, enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'h0010));
    load(16'h0001, enc(OP_LD,  3'd2, 3'd0, 3'd0, 16'h0011));
    load(16'h0002, enc(OP_SUB, 3'd3, 3'd1, 3'd2, 16'h0000));
    load(16'h0003, enc(OP_JZ,  3'd0, 3'd0, 3'd0, 16'h0020));
    load(16'h0004, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
    load(16'h0010, 32'h0000_0007);
    load(16'h0011, 32'h0000_0005);
    rst = 1'b0;
    run(14);
    chk("jz_n_pc", 32'(pc), 32'h4);
    chk("jz_n_flags", 32'(flags), 32'h0);
    chk("jz_n_r3", dut.u_rf.regs_q[3], 32'h2);
    run(2);
    chk("jz_n_halt", 32'(halted), 32'h1);
    chk("jz_n_halt_pc", 32'(pc), 32'h5);

    // STR then LD back
    clear_mem();
    load(16'h0000, enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'h0010));
    load(16'h0001, enc(OP_STR, 3'd0, 3'd1, 3'd0, 16'h0030));
    load(16'h0002, enc(OP_LD,  3'd4, 3'd0, 3'd0, 16'h0030));
    load(16'h0003, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
    load(16'h0010, 32'hDEAD_BEEF);
    rst = 1'b0;
    we_cnt = 0; we_cyc = 0; we_addr = '0; we_data = '0;
    for (int c = 1; c <= 13; c++) begin
      run(1);
      if (mem_we) begin
        we_cnt++;
        we_cyc  = c;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
    end
    chk("str_we_count", 32'(we_cnt), 32'h1);
    chk("str_we_cycle", 32'(we_cyc), 32'h6);
    chk("str_we_addr", 32'(we_addr), 32'h30);
    chk("str_we_data", we_data, 32'hDEAD_BEEF);
    chk("str_mem", mem[16'h0030], 32'hDEAD_BEEF);
    chk("str_ld_r4", dut.u_rf.regs_q[4], 32'hDEAD_BEEF);
    chk("str_halt", 32'(halted), 32'h1);

    // ADD leaves C=1, MUL must keep it
    clear_mem();
    load(16'h0000, enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'h0010));
    load(16'h0001, enc(OP_LD,  3'd2, 3'd0, 3'd0, 16'h0011));
    load(16'h0002, enc(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000));
    load(16'h0003, enc(OP_LD,  3'd4, 3'd0, 3'd0, 16'h0012));
    load(16'h0004, enc(OP_LD,  3'd5, 3'd0, 3'd0, 16'h0013));
    load(16'h0005, enc(OP_MUL, 3'd6, 3'd4, 3'd5, 16'h0000));
    load(16'h0006, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
    load(16'h0010, 32'hFFFF_FFFF);
    load(16'h0011, 32'h0000_0001);
    load(16'h0012, 32'h0000_0003);
    load(16'h0013, 32'h0000_0005);
    rst = 1'b0;
    run(12);
    chk("mul_add_flags", 32'(flags), 32'h9);
    run(14);
    chk("mul_r6", dut.u_rf.regs_q[6], 32'hF);
    chk("mul_flags", 32'(flags), 32'h8);
    chk("mul_halt", 32'(halted), 32'h1);
    chk("mul_pc", 32'(pc), 32'h7);

    // reset during the STR memory cycle
    clear_mem();
    load(16'h0000, enc(OP_LD,  3'd1, 3'd0, 3'd0, 16'h0010));
    load(16'h0001, enc(OP_STR, 3'd0, 3'd1, 3'd0, 16'h0030));
    load(16'h0002, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
    load(16'h0010, 32'hDEAD_BEEF);
    load(16'h0030, 32'h1234_5678);
    rst = 1'b0;
    run(6);
    chk("rstmid_we_before", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstmid_we_drop", 32'(mem_we), 32'h0);
    run(1);
    chk("rstmid_mem", mem[16'h0030], 32'h1234_5678);
    chk("rstmid_pc", 32'(pc), 32'h0);
    for (int r = 0; r < 8; r++)
      chk($sformatf("rstmid_r%0d", r), dut.u_rf.regs_q[r], 32'h0);

    // undefined opcode is flagged and skipped
    clear_mem();
    load(16'h0000, enc(5'h1F,  3'd0, 3'd0, 3'd0, 16'h0000));
    load(16'h0001, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
    rst = 1'b0;
    run(2);
    chk("ill_set", 32'(illegal), 32'h1);
    chk("ill_not_halted", 32'(halted), 32'h0);
    chk("ill_pc", 32'(pc), 32'h1);
    run(2);
    chk("ill_halt", 32'(halted), 32'h1);
    chk("ill_sticky", 32'(illegal), 32'h1);
    chk("ill_halt_pc", 32'(pc), 32'h2);

    // JMP to top of memory, fetch wraps pc to zero
    clear_mem();
    load(16'h0000, enc(OP_JMP, 3'd0, 3'd0, 3'd0, 16'hFFFF));
    load(16'hFFFF, enc(OP_HLT, 3'd0, 3'd0, 3'd0, 16'h0000));
    rst = 1'b0;
    run(2);
    chk("jmp_pc", 32'(pc), 32'hFFFF);
    run(1);
    chk("wrap_pc", 32'(pc), 32'h0);
    run(1);
    chk("wrap_halt", 32'(halted), 32'h1);
    run(5);
    chk("halt_pc_frozen", 32'(pc), 32'h0);
    chk("halt_stays", 32'(halted), 32'h1);
    chk("halt_no_we", 32'(mem_we), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
